// File: rtl/cache_control.sv
// Controller FSM for a 2-way, 8-set, 128-bit-line cache: hit/miss decision, dirty writeback, line fill.
// Hit completes in 1 cycle; misses wait on pmem_resp; saturating hit/miss/writeback counters.
module cache_control #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem_read,
    input  logic                 mem_write,
    output logic                 mem_resp,
    output logic                 pmem_read,
    output logic                 pmem_write,
    input  logic                 pmem_resp,
    output logic                 pmem_addr_sel,
    input  logic                 dp_hit,
    input  logic                 dp_dirty,
    output logic                 dp_write_enable,
    output logic                 dp_control_load,
    output logic                 dp_lru_load,
    output logic                 dp_data_sel,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count,
    output logic [CNT_WIDTH-1:0] wb_count
);

    typedef enum logic [1:0] {
        S_COMPARE   = 2'd0,
        S_WRITEBACK = 2'd1,
        S_ALLOCATE  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 miss_seen_q, miss_seen_d;
    logic [CNT_WIDTH-1:0] hit_count_q, hit_count_d;
    logic [CNT_WIDTH-1:0] miss_count_q, miss_count_d;
    logic [CNT_WIDTH-1:0] wb_count_q, wb_count_d;
    logic                 req;
    logic                 hit_inc, miss_inc, wb_inc;

    assign req = mem_read | mem_write;

    always_comb begin
        state_d         = state_q;
        miss_seen_d     = miss_seen_q;
        hit_inc         = 1'b0;
        miss_inc        = 1'b0;
        wb_inc          = 1'b0;
        mem_resp        = 1'b0;
        pmem_read       = 1'b0;
        pmem_write      = 1'b0;
        pmem_addr_sel   = 1'b0;
        dp_write_enable = 1'b0;
        dp_control_load = 1'b0;
        dp_lru_load     = 1'b0;
        dp_data_sel     = 1'b0;

        case (state_q)
            S_COMPARE: begin
                if (req && dp_hit) begin
                    mem_resp        = 1'b1;
                    dp_lru_load     = 1'b1;
                    dp_write_enable = mem_write;
                    // The hit that retires a miss is not counted as a hit.
                    hit_inc         = !miss_seen_q;
                    miss_seen_d     = 1'b0;
                end else if (req) begin
                    miss_inc    = 1'b1;
                    miss_seen_d = 1'b1;
                    state_d     = dp_dirty ? S_WRITEBACK : S_ALLOCATE;
                end
            end
            S_WRITEBACK: begin
                pmem_write    = 1'b1;
                pmem_addr_sel = 1'b1;
                if (pmem_resp) begin
                    wb_inc  = 1'b1;
                    state_d = S_ALLOCATE;
                end
            end
            S_ALLOCATE: begin
                pmem_read   = 1'b1;
                dp_data_sel = 1'b1;
                if (pmem_resp) begin
                    dp_control_load = 1'b1;
                    state_d         = S_COMPARE;
                end
            end
            default: state_d = S_COMPARE;
        endcase

        // Outputs drop combinationally while reset is held, not just after the next edge.
        if (reset) begin
            mem_resp        = 1'b0;
            pmem_read       = 1'b0;
            pmem_write      = 1'b0;
            pmem_addr_sel   = 1'b0;
            dp_write_enable = 1'b0;
            dp_control_load = 1'b0;
            dp_lru_load     = 1'b0;
            dp_data_sel     = 1'b0;
        end

        hit_count_d  = (hit_inc  && hit_count_q  != '1) ? hit_count_q  + CNT_WIDTH'(1) : hit_count_q;
        miss_count_d = (miss_inc && miss_count_q != '1) ? miss_count_q + CNT_WIDTH'(1) : miss_count_q;
        wb_count_d   = (wb_inc   && wb_count_q   != '1) ? wb_count_q   + CNT_WIDTH'(1) : wb_count_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_COMPARE;
            miss_seen_q  <= 1'b0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
            wb_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            miss_seen_q  <= miss_seen_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
            wb_count_q   <= wb_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
    assign wb_count   = wb_count_q;

endmodule

// File: tb/tb_cache_control.sv
// Directed bench for cache_control: scoreboard of expected responses, pmem model with programmable latency.
module tb_cache_control;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read, mem_write, mem_resp;
    logic        pmem_read, pmem_write, pmem_resp, pmem_addr_sel;
    logic        dp_hit, dp_dirty;
    logic        dp_write_enable, dp_control_load, dp_lru_load, dp_data_sel;
    logic [15:0] hit_count, miss_count, wb_count;

    logic        mem_read2, mem_resp2, pmem_read2, pmem_write2, pmem_addr_sel2;
    logic        dp_hit2, we2, cl2, lru2, ds2;
    logic [1:0]  hit_count2, miss_count2, wb_count2;

    int passes = 0;
    int total  = 0;
    int exp_hit = 0, exp_miss = 0, exp_wb = 0;

    typedef struct {
        int    lat;
        logic  we;
        string tag;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    cache_control #(.CNT_WIDTH(16)) u_dut (
        .clk(clk), .reset(reset),
        .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
        .pmem_addr_sel(pmem_addr_sel), .dp_hit(dp_hit), .dp_dirty(dp_dirty),
        .dp_write_enable(dp_write_enable), .dp_control_load(dp_control_load),
        .dp_lru_load(dp_lru_load), .dp_data_sel(dp_data_sel),
        .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
    );

    cache_control #(.CNT_WIDTH(2)) u_dut2 (
        .clk(clk), .reset(reset),
        .mem_read(mem_read2), .mem_write(1'b0), .mem_resp(mem_resp2),
        .pmem_read(pmem_read2), .pmem_write(pmem_write2), .pmem_resp(1'b0),
        .pmem_addr_sel(pmem_addr_sel2), .dp_hit(dp_hit2), .dp_dirty(1'b0),
        .dp_write_enable(we2), .dp_control_load(cl2),
        .dp_lru_load(lru2), .dp_data_sel(ds2),
        .hit_count(hit_count2), .miss_count(miss_count2), .wb_count(wb_count2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_hit_count"},  32'(hit_count),  32'(exp_hit));
        check({tag, "_miss_count"}, 32'(miss_count), 32'(exp_miss));
        check({tag, "_wb_count"},   32'(wb_count),   32'(exp_wb));
    endtask

    // Drives one CPU request, models pmem with latency n and the datapath hit after a fill.
    task automatic run_req(input string tag, input logic rd, input logic wr,
                           input logic hit0, input logic dirty, input int n,
                           input int lat, input logic we);
        exp_t e;
        int   pm_cnt = 0, rd_cyc = 0, wr_cyc = 0;
        logic fill_done = 1'b0, done = 1'b0, both_seen = 1'b0, sel_bad = 1'b0;
        e.lat = lat; e.we = we; e.tag = tag;
        sb.push_back(e);
        for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 1) begin
                mem_read = rd; mem_write = wr; dp_hit = hit0; dp_dirty = dirty;
            end
            if (fill_done) dp_hit = 1'b1;
            if (pmem_read || pmem_write) begin
                pm_cnt++;
                pmem_resp = (pm_cnt == n);
            end else begin
                pmem_resp = 1'b0;
            end
            @(negedge clk);
            if (pmem_read && pmem_write) both_seen = 1'b1;
            if (pmem_write && !pmem_addr_sel) sel_bad = 1'b1;
            if (pmem_read && (pmem_addr_sel || !dp_data_sel)) sel_bad = 1'b1;
            if (pmem_read) rd_cyc++;
            if (pmem_write) wr_cyc++;
            if (pmem_resp && pmem_read) begin
                check({tag, "_control_load"}, 32'(dp_control_load), 32'd1);
                fill_done = 1'b1;
            end
            if (pmem_resp) pm_cnt = 0;
            if (mem_resp) begin
                e = sb.pop_front();
                check({e.tag, "_latency"},   32'(cyc), 32'(e.lat));
                check({e.tag, "_write_en"},  32'(dp_write_enable), 32'(e.we));
                check({e.tag, "_lru_load"},  32'(dp_lru_load), 32'd1);
                check({e.tag, "_data_sel"},  32'(dp_data_sel), 32'd0);
                done = 1'b1;
            end
        end
        check({tag, "_resp_seen"},   32'(done), 32'd1);
        check({tag, "_pmem_both"},   32'(both_seen), 32'd0);
        check({tag, "_addr_sel"},    32'(sel_bad), 32'd0);
        check({tag, "_read_cycles"}, 32'(rd_cyc), 32'(hit0 ? 0 : n));
        check({tag, "_write_cycles"}, 32'(wr_cyc), 32'((!hit0 && dirty) ? n : 0));
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0; dp_hit = 1'b0; dp_dirty = 1'b0;
        if (!done) void'(sb.pop_back());
    endtask

    initial begin
        reset = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
        dp_hit = 1'b0; dp_dirty = 1'b0;
        mem_read2 = 1'b0; dp_hit2 = 1'b0;
        #12;
        check("rst_pmem_read", 32'(pmem_read), 32'd0);
        check("rst_mem_resp",  32'(mem_resp), 32'd0);
        check_counters("rst");
        @(negedge clk);
        reset = 1'b0;

        run_req("t1_read_hit", 1'b1, 1'b0, 1'b1, 1'b0, 3, 1, 1'b0);
        exp_hit = 1;
        check_counters("t1");

        run_req("t2_write_clean_miss", 1'b0, 1'b1, 1'b0, 1'b0, 3, 5, 1'b1);
        exp_miss = 1;
        check_counters("t2");

        run_req("t3_read_dirty_miss", 1'b1, 1'b0, 1'b0, 1'b1, 2, 6, 1'b0);
        exp_miss = 2; exp_wb = 1;
        check_counters("t3");

        run_req("t6_rw_priority", 1'b1, 1'b1, 1'b1, 1'b0, 3, 1, 1'b1);
        exp_hit = 2;
        check_counters("t6");

        run_req("t7_write_dirty_n1", 1'b0, 1'b1, 1'b0, 1'b1, 1, 4, 1'b1);
        exp_miss = 3; exp_wb = 2;
        check_counters("t7");

        // Reset in the middle of a line fill.
        @(posedge clk); #1;
        mem_read = 1'b1; dp_hit = 1'b0; dp_dirty = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("t4_in_allocate", 32'(pmem_read), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("t4_rst_pmem_read",  32'(pmem_read), 32'd0);
        check("t4_rst_pmem_write", 32'(pmem_write), 32'd0);
        check("t4_rst_data_sel",   32'(dp_data_sel), 32'd0);
        exp_hit = 0; exp_miss = 0; exp_wb = 0;
        check_counters("t4_rst");
        mem_read = 1'b0;
        @(posedge clk); #2;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_idle_pmem", 32'({pmem_read, pmem_write}), 32'd0);
            check("t4_idle_resp", 32'(mem_resp), 32'd0);
        end
        run_req("t4_post_rst_hit", 1'b1, 1'b0, 1'b1, 1'b0, 3, 1, 1'b0);
        exp_hit = 1;
        check_counters("t4_post");

        // Saturating 2-bit counter on the second instance.
        check("t5_start", 32'(hit_count2), 32'd0);
        @(posedge clk); #1;
        mem_read2 = 1'b1; dp_hit2 = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check("t5_resp", 32'(mem_resp2), 32'd1);
            @(posedge clk); #1;
            check("t5_hit_count", 32'(hit_count2), 32'(k > 3 ? 3 : k));
        end
        mem_read2 = 1'b0; dp_hit2 = 1'b0;
        check("t5_miss_count", 32'(miss_count2), 32'd0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
